wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 14 +
 rtl/wb_regfile_wb_mux.sv | 16 +
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the write-back register file.
package wb_regfile_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned NumRegs = 32;
  localparam logic [AddrW-1:0] ZeroReg = 5'd0;

  // A write commits only when enabled and not aimed at the hard-wired zero register.
  function automatic logic wr_qualified(input logic en, input logic [AddrW-1:0] dest);
    return en && (dest != ZeroReg);
  endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 write-back source select: memory load data or ALU result.
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic             i_sel,
  input  logic [DataW-1:0] i_alu,
  input  logic [DataW-1:0] i_mem,
  output logic [DataW-1:0] o_y
);

  // Pure combinational select, no state.
  always_comb begin
    o_y = i_sel ? i_mem : i_alu;
  end

endmodule

// File: rtl/wb_regfile.sv
// 31x32 register file with write-through bypass and committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             wwreg,
  input  logic             wm2reg,
  input  logic [AddrW-1:0] wdestReg,
  input  logic [DataW-1:0] wr,
  input  logic [DataW-1:0] wdo,
  input  logic [AddrW-1:0] rna,
  input  logic [AddrW-1:0] rnb,
  output logic [DataW-1:0] qa,
  output logic [DataW-1:0] qb,
  output logic [DataW-1:0] wbdata,
  output logic [DataW-1:0] wb_count
);

  logic [DataW-1:0] w_wbdata;
  logic             w_wr_en;
  logic [DataW-1:0] r_regs [1:NumRegs-1];
  logic [DataW-1:0] r_wb_count;

  wb_mux u_wb_mux (
    .i_sel (wm2reg),
    .i_alu (wr),
    .i_mem (wdo),
    .o_y   (w_wbdata)
  );

  assign w_wr_en  = wr_qualified(wwreg, wdestReg);
  assign wbdata   = w_wbdata;
  assign wb_count = r_wb_count;

  // Register 0 is not stored; each remaining register owns its own write decode.
  for (genvar g = 1; g < NumRegs; g++) begin : g_reg
    // Store write-back data when this register is the qualified destination.
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        r_regs[g] <= '0;
      end else if (w_wr_en && (wdestReg == AddrW'(g))) begin
        r_regs[g] <= w_wbdata;
      end
    end
  end

  // Count committed writes; wraps silently.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wb_count <= '0;
    end else if (w_wr_en) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  // Port A: zero in reset or for r0, bypass on a same-cycle write, else stored value.
  always_comb begin
    qa = '0;
    if (clrn && (rna != ZeroReg)) begin
      if (w_wr_en && (wdestReg == rna)) begin
        qa = w_wbdata;
      end else begin
        qa = r_regs[rna];
      end
    end
  end

  // Port B: identical rule to port A so both ports always agree.
  always_comb begin
    qb = '0;
    if (clrn && (rnb != ZeroReg)) begin
      if (w_wr_en && (wdestReg == rnb)) begin
        qb = w_wbdata;
      end else begin
        qb = r_regs[rnb];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        clrn;
  logic        wwreg;
  logic        wm2reg;
  logic [4:0]  wdestReg;
  logic [31:0] wr;
  logic [31:0] wdo;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] wbdata;
  logic [31:0] wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile dut (
    .clk      (clk),
    .clrn     (clrn),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wdestReg (wdestReg),
    .wr       (wr),
    .wdo      (wdo),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .wbdata   (wbdata),
    .wb_count (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0; wwreg = 1'b0; wm2reg = 1'b0; wdestReg = 5'd0;
    wr = 32'd0; wdo = 32'd0; rna = 5'd0; rnb = 5'd0;
    #2;
    check("rst_count", wb_count, 32'd0);
    // wbdata keeps following the select while in reset; reads stay zero even with bypass.
    wwreg = 1'b1; wdestReg = 5'd5; rna = 5'd5; rnb = 5'd5;
    wr = 32'h0000_0011; wdo = 32'h0000_0022; wm2reg = 1'b0;
    #1;
    check("rst_wbdata_alu", wbdata, 32'h0000_0011);
    check("rst_qa_bypass", qa, 32'd0);
    check("rst_qb_bypass", qb, 32'd0);
    wm2reg = 1'b1;
    #1;
    check("rst_wbdata_mem", wbdata, 32'h0000_0022);
    step();
    check("rst_write_ignored", wb_count, 32'd0);
    wwreg = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("rst_reg5_zero", qa, 32'd0);

    // Basic ALU write then read.
    wwreg = 1'b1; wm2reg = 1'b0; wdestReg = 5'd5; wr = 32'h1234_5678; rna = 5'd0; rnb = 5'd0;
    step();
    wwreg = 1'b0; rna = 5'd5;
    #1;
    check("alu_write_qa", qa, 32'h1234_5678);
    check("alu_write_count", wb_count, 32'd1);

    // Memory-source write with both ports bypassing before the edge.
    wwreg = 1'b1; wm2reg = 1'b1; wdestReg = 5'd9; wdo = 32'hCAFE_F00D; wr = 32'h0;
    rna = 5'd9; rnb = 5'd9;
    #1;
    check("bypass_qa", qa, 32'hCAFE_F00D);
    check("bypass_qb", qb, 32'hCAFE_F00D);
    step();
    wwreg = 1'b0;
    #1;
    check("mem_write_qa", qa, 32'hCAFE_F00D);
    check("mem_write_count", wb_count, 32'd2);

    // Write to r0 is discarded and not counted.
    wwreg = 1'b1; wm2reg = 1'b0; wdestReg = 5'd0; wr = 32'hFFFF_FFFF; rna = 5'd0; rnb = 5'd0;
    #1;
    check("r0_bypass_qa", qa, 32'd0);
    step();
    check("r0_after_qa", qa, 32'd0);
    check("r0_count", wb_count, 32'd2);

    // Disabled writes leave state untouched.
    wdestReg = 5'd3; wr = 32'hA5A5_A5A5; rna = 5'd3;
    step();
    check("r3_write_count", wb_count, 32'd3);
    wwreg = 1'b0; wr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      wm2reg = i[0];
      wdo = 32'h5555_0000 + i;
      step();
      check("r3_hold_qa", qa, 32'hA5A5_A5A5);
    end
    check("r3_hold_count", wb_count, 32'd3);

    // Bypass on one port only; the other port reads stored data.
    wwreg = 1'b1; wm2reg = 1'b0; wdestReg = 5'd3; wr = 32'h0BAD_BEEF; rna = 5'd5; rnb = 5'd3;
    #1;
    check("split_qa_stored", qa, 32'h1234_5678);
    check("split_qb_bypass", qb, 32'h0BAD_BEEF);
    step();
    check("split_count", wb_count, 32'd4);

    // Fill every register, then read all back.
    for (int i = 1; i < 32; i++) begin
      wdestReg = 5'(i); wr = 32'h1000_0000 + i;
      step();
    end
    wwreg = 1'b0;
    check("fill_count", wb_count, 32'd35);
    for (int i = 1; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i + 1);
      #1;
      check("fill_qa", qa, 32'h1000_0000 + i);
      check("fill_qb", qb, 32'h1000_0000 + (32 - i));
    end

    // Reset mid-cycle with a qualified write pending: clears with no clock edge.
    @(negedge clk);
    #2;
    wwreg = 1'b1; wdestReg = 5'd7; wr = 32'h0000_0077;
    #1;
    clrn = 1'b0;
    #1;
    check("mid_rst_count", wb_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(i);
      #0.1;
      check("mid_rst_qa", qa, 32'd0);
      check("mid_rst_qb", qb, 32'd0);
    end
    step();
    check("mid_rst_edge_count", wb_count, 32'd0);
    rna = 5'd7;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("post_rst_reg7_bypass", qa, 32'h0000_0077);
    step();
    wwreg = 1'b0;
    #1;
    check("post_rst_reg7", qa, 32'h0000_0077);
    check("post_rst_count", wb_count, 32'd1);
    rna = 5'd5;
    #1;
    check("post_rst_reg5", qa, 32'd0);

    // Counter wrap.
    force dut.r_wb_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_wb_count;
    #1;
    check("wrap_preset", wb_count, 32'hFFFF_FFFE);
    wwreg = 1'b1; wdestReg = 5'd1; wr = 32'h1;
    step();
    check("wrap_max", wb_count, 32'hFFFF_FFFF);
    wdestReg = 5'd2; wr = 32'h2;
    step();
    check("wrap_zero", wb_count, 32'h0000_0000);
    wwreg = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
